// File: rtl/kyber_byte_encode.sv
// kyber_byte_encode: Kyber ByteEncode_d packer, NCOEF coefficients in, OUT_W-bit words out.
// Build option: define KYBER_ENC_RANGE_CHK_EN to flag out-of-range coefficients on o_err.
module kyber_byte_encode #(
  parameter int OUT_W    = 64,
  parameter int NCOEF    = 2,
  parameter int COEF_W   = 12,
  parameter int NUM_COEF = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [3:0]              i_l,
  input  logic [NCOEF*COEF_W-1:0] i_coeffs,
  input  logic                    i_coeffs_valid,
  output logic                    o_coeffs_ready,
  output logic [OUT_W-1:0]        o_obytes,
  output logic                    o_obytes_valid,
  input  logic                    i_obytes_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  // state  | meaning
  // S_IDLE | waiting for i_start with a supported d
  // S_COMP | accepting coefficient beats and emitting packed words
  // S_DONE | one-cycle done pulse, then back to S_IDLE

  localparam int BEAT_W = NCOEF * COEF_W;
  localparam int ACC_W  = OUT_W + BEAT_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CCNT_W = $clog2(NUM_COEF + 1);
  localparam int D_MAX  = 12;
  localparam int WCNT_W = $clog2(NUM_COEF * D_MAX / 8 + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          d_q;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_base;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_base;
  logic [CCNT_W-1:0]   coef_cnt_q;
  logic [WCNT_W-1:0]   words_left_q;
  logic [COEF_W-1:0]   lane_mask;
  logic [BEAT_W-1:0]   beat_bits;
  logic                start_ok, beat_fire, drain, word_hs, last_word;

  function automatic logic d_supported(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_supported = 1'b1;
      default:                               d_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [WCNT_W-1:0] words_for(input logic [3:0] d);
    int unsigned n;
    n = (32'(NUM_COEF) * 32'(d)) / 32'(OUT_W);
    words_for = n[WCNT_W-1:0];
  endfunction

  assign start_ok       = (state_q == S_IDLE) && i_start && d_supported(i_l);
  assign o_coeffs_ready = (state_q == S_COMP) && (coef_cnt_q < CCNT_W'(NUM_COEF))
                          && (fill_q < FILL_W'(OUT_W));
  assign beat_fire      = o_coeffs_ready && i_coeffs_valid;
  assign drain          = (fill_q >= FILL_W'(OUT_W)) && (!o_obytes_valid || i_obytes_ready);
  assign word_hs        = o_obytes_valid && i_obytes_ready;
  assign last_word      = word_hs && (words_left_q == WCNT_W'(1));

  // Wraps to all-ones when d equals the lane width.
  assign lane_mask = (COEF_W'(1) << d_q) - COEF_W'(1);

  always_comb begin : pack_beat
    logic [COEF_W-1:0] lane;
    beat_bits = '0;
    lane      = '0;
    for (int k = 0; k < NCOEF; k++) begin
      lane      = i_coeffs[k*COEF_W +: COEF_W] & lane_mask;
      beat_bits = beat_bits | (BEAT_W'(lane) << (k * int'(d_q)));
    end
  end

  // Drain first, then append the new beat just above the remaining fill.
  always_comb begin
    acc_base  = drain ? (acc_q >> OUT_W) : acc_q;
    fill_base = drain ? (fill_q - FILL_W'(OUT_W)) : fill_q;
    acc_d     = acc_base;
    fill_d    = fill_base;
    if (beat_fire) begin
      acc_d  = acc_base | (ACC_W'(beat_bits) << fill_base);
      fill_d = fill_base + FILL_W'(NCOEF * int'(d_q));
    end
  end

  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_COMP;
      S_COMP: begin
        o_busy = 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      d_q            <= '0;
      acc_q          <= '0;
      fill_q         <= '0;
      coef_cnt_q     <= '0;
      words_left_q   <= '0;
      o_obytes       <= '0;
      o_obytes_valid <= 1'b0;
    end else if (start_ok) begin
      d_q            <= i_l;
      acc_q          <= '0;
      fill_q         <= '0;
      coef_cnt_q     <= '0;
      words_left_q   <= words_for(i_l);
      o_obytes_valid <= 1'b0;
    end else begin
      if (drain || beat_fire) begin
        acc_q  <= acc_d;
        fill_q <= fill_d;
      end
      if (beat_fire) coef_cnt_q <= coef_cnt_q + CCNT_W'(NCOEF);
      if (drain) begin
        o_obytes       <= acc_q[OUT_W-1:0];
        o_obytes_valid <= 1'b1;
      end else if (i_obytes_ready) begin
        o_obytes_valid <= 1'b0;
      end
      if (word_hs) words_left_q <= words_left_q - WCNT_W'(1);
    end
  end

`ifdef KYBER_ENC_RANGE_CHK_EN
  logic lane_bad;
  logic err_q;

  // d=12 lanes are checked against q; narrower d against 2^d.
  always_comb begin : range_chk
    logic [COEF_W-1:0] lane;
    lane_bad = 1'b0;
    lane     = '0;
    for (int k = 0; k < NCOEF; k++) begin
      lane = i_coeffs[k*COEF_W +: COEF_W];
      if (d_q == 4'd12) begin
        if (32'(lane) >= 32'd3329) lane_bad = 1'b1;
      end else if ((lane & ~lane_mask) != '0) begin
        lane_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (beat_fire && lane_bad) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
